// File: rtl/cam_pkg.sv
// Shared camera / frame-buffer definitions: pixel format, capture states, colour conversion.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cam_pkg;

    // Default geometry of the frame buffer shared by capture and scan-out.
    localparam int H_PIXELS   = 640;
    localparam int V_LINES    = 480;
    localparam int FB_PIXELS  = H_PIXELS * V_LINES;
    localparam int ADDR_WIDTH = 19;

    // Frame-buffer word: {R[3:0], G[3:0], B[3:0]}.
    typedef logic [11:0] pixel444_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        ACTIVE
    } cap_state_e;

    // hi = {R5[4:0], G6[5:3]}, lo = {G6[2:0], B5[4:0]}; keep the top 4 bits of each channel.
    function automatic pixel444_t rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Single-bit synchroniser (STAGES_g flops) with rise/fall detect on the synchronised value.
// Latency: STAGES_g clk to sync_o; edges are combinational from sync_o and the flop behind it.
// Backpressure: none, free-running.
//
// Ports: clk_i/rst_i (sync, active-high), async_i (asynchronous input),
//        sync_o (synchronised level), rise_o / fall_o (one-clk edge strobes).
module cam_sync #(
    parameter int STAGES_g = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES_g-1:0] sync_q;
    logic                prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES_g-2:0], async_i};
            prev_q <= sync_q[STAGES_g-1];
        end
    end

    assign sync_o = sync_q[STAGES_g-1];
    assign rise_o = sync_q[STAGES_g-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES_g-1] & prev_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: samples the OV7670-style bus in clk_i, packs RGB565 byte pairs into RGB444 frame-buffer writes.
// Latency: last camera byte at the pin -> fb_we_o = SYNC_STAGES_g + 2 clk.
// Backpressure: none; the frame-buffer port always accepts, pixels past the end of the buffer are dropped.
//
// Ports: clk_i, rst_i (sync, active-high), capture_en_i (arm / stop at frame boundary),
//        cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i[7:0] (asynchronous camera bus),
//        fb_we_o, fb_addr_o, fb_data_o (frame-buffer write port),
//        frame_done_o (end-of-frame pulse), frame_err_o (sticky pixel-count error for the last frame).
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS_g    = 640,
    parameter int V_LINES_g     = 480,
    parameter int ADDR_WIDTH_g  = 19,
    parameter int SYNC_STAGES_g = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    capture_en_i,
    input  logic                    cam_pclk_i,
    input  logic                    cam_href_i,
    input  logic                    cam_vsync_i,
    input  logic [7:0]              cam_data_i,
    output logic                    fb_we_o,
    output logic [ADDR_WIDTH_g-1:0] fb_addr_o,
    output pixel444_t               fb_data_o,
    output logic                    frame_done_o,
    output logic                    frame_err_o
);

    // One extra bit so the counter can hold the full-frame count itself.
    localparam int                CNT_W  = ADDR_WIDTH_g + 1;
    localparam logic [CNT_W-1:0]  FB_PIX = CNT_W'(H_PIXELS_g * V_LINES_g);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic pclk_sync, pclk_rise, pclk_fall;
    logic href_sync, href_rise, href_fall;
    logic vs_sync,   vs_rise,   vs_fall;
    logic unused_sync;

    cam_sync #(.STAGES_g(SYNC_STAGES_g)) u_sync_pclk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cam_pclk_i),
        .sync_o  (pclk_sync),
        .rise_o  (pclk_rise),
        .fall_o  (pclk_fall)
    );

    cam_sync #(.STAGES_g(SYNC_STAGES_g)) u_sync_href (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cam_href_i),
        .sync_o  (href_sync),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    cam_sync #(.STAGES_g(SYNC_STAGES_g)) u_sync_vs (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (cam_vsync_i),
        .sync_o  (vs_sync),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    assign unused_sync = ^{pclk_sync, pclk_fall, href_rise, vs_sync};

    // Data bus: same depth as the control synchronisers so the byte lines up with the synced pclk edge.
    // The byte is stable around the pclk edge because pclk runs at most clk_i/4.
    logic [7:0] data_q [SYNC_STAGES_g];
    logic [7:0] byte_dat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES_g; i++) data_q[i] <= '0;
        end else begin
            data_q[0] <= cam_data_i;
            for (int i = 1; i < SYNC_STAGES_g; i++) data_q[i] <= data_q[i-1];
        end
    end

    assign byte_dat = data_q[SYNC_STAGES_g-1];

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_e state_q, state_d;
    logic       frame_start;
    logic       frame_end;
    logic       byte_take;
    logic       byte_vld;

    assign byte_vld = pclk_rise & href_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        byte_take   = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_en_i) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    frame_start = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                // A frame always runs to its vsync; capture_en_i only decides where we go afterwards.
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = capture_en_i ? WAIT_VS : IDLE;
                end
                // Any vsync edge in the same clk as a byte edge wins; the byte is discarded.
                byte_take = byte_vld & ~vs_rise & ~vs_fall;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel assembly and frame-buffer write port
    // ------------------------------------------------------------------
    logic                    phase_q;   // 0: expecting hi byte, 1: expecting lo byte
    logic [7:0]              hi_q;
    logic [CNT_W-1:0]        pix_cnt_q; // next write address, saturates at FB_PIX
    logic                    ovf_q;     // a complete pixel arrived after the buffer was full
    logic                    pend_q;    // assembled pixel waiting to be written next clk
    logic [ADDR_WIDTH_g-1:0] pend_addr_q;
    pixel444_t               pend_pix_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pix_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            pend_pix_q   <= '0;
            fb_we_o      <= 1'b0;
            fb_addr_o    <= '0;
            fb_data_o    <= '0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            fb_we_o      <= pend_q;
            pend_q       <= 1'b0;

            // Address and data only move on a write so the buffer port sees stable values in between.
            if (pend_q) begin
                fb_addr_o <= pend_addr_q;
                fb_data_o <= pend_pix_q;
            end

            if (frame_start) begin
                phase_q     <= 1'b0;
                pix_cnt_q   <= '0;
                ovf_q       <= 1'b0;
                frame_err_o <= 1'b0;
            end else if (frame_end) begin
                // A half pixel pending at vsync is dropped.
                phase_q     <= 1'b0;
                frame_err_o <= ovf_q | (pix_cnt_q != FB_PIX);
            end else if (state_q == ACTIVE) begin
                // Odd byte count on a line: discard the orphan hi byte.
                if (href_fall) phase_q <= 1'b0;

                if (byte_take) begin
                    if (!phase_q) begin
                        hi_q    <= byte_dat;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        if (pix_cnt_q < FB_PIX) begin
                            pend_q      <= 1'b1;
                            pend_addr_q <= pix_cnt_q[ADDR_WIDTH_g-1:0];
                            pend_pix_q  <= rgb565_to_444(hi_q, byte_dat);
                            pix_cnt_q   <= pix_cnt_q + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture at 4x2 pixels, 3-bit addresses, 2 sync stages.
// Camera bus is driven at clk/4; a negedge monitor logs every write and frame_done pulse.
// Backpressure: n/a.
module tb_cam_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       capture_en = 1'b0;
    logic       cam_pclk = 1'b0;
    logic       cam_href = 1'b0;
    logic       cam_vsync = 1'b1;
    logic [7:0] cam_data = 8'h00;
    logic       fb_we;
    logic [2:0] fb_addr;
    logic [11:0] fb_data;
    logic       frame_done;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  wr_addr [$];
    logic [11:0] wr_data [$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    cam_capture #(
        .H_PIXELS_g    (4),
        .V_LINES_g     (2),
        .ADDR_WIDTH_g  (3),
        .SYNC_STAGES_g (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .capture_en_i (capture_en),
        .cam_pclk_i   (cam_pclk),
        .cam_href_i   (cam_href),
        .cam_vsync_i  (cam_vsync),
        .cam_data_i   (cam_data),
        .fb_we_o      (fb_we),
        .fb_addr_o    (fb_addr),
        .fb_data_o    (fb_data),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err)
    );

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            wr_addr.push_back(fb_addr);
            wr_data.push_back(fb_data);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] log_data(input int i);
        return (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        tick(2);
    endtask

    // Line of nbytes alternating hi, lo, hi, ...
    task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) send_byte((i % 2 == 0) ? hi : lo);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(4);
    endtask

    task automatic frame_begin();
        cam_vsync = 1'b0;
        tick(6);
    endtask

    task automatic frame_close();
        cam_vsync = 1'b1;
        tick(8);
    endtask

    int lat;

    initial begin
        // ---------------- reset state ----------------
        tick(4);
        check("rst_we",   32'(fb_we), 0);
        check("rst_addr", 32'(fb_addr), 0);
        check("rst_data", 32'(fb_data), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_err",  32'(frame_err), 0);
        rst = 1'b0;
        tick(2);

        // ---------------- 1: full frame of F8/00 ----------------
        capture_en = 1'b1;
        tick(2);
        clr_log();
        frame_begin();
        send_line(8, 8'hF8, 8'h00);
        send_line(8, 8'hF8, 8'h00);
        frame_close();
        check("t1_nwr", wr_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_addr%0d", i), log_addr(i), i);
            check($sformatf("t1_data%0d", i), log_data(i), 32'hF00);
        end
        check("t1_done", done_cnt, 1);
        check("t1_err", 32'(frame_err), 0);
        check("t1_we_idle", 32'(fb_we), 0);
        check("t1_addr_hold", 32'(fb_addr), 7);

        // ---------------- 2: colour conversion + latency ----------------
        clr_log();
        frame_begin();
        cam_href = 1'b1;
        send_byte(8'h07);
        cam_data = 8'hE0;
        cam_pclk = 1'b0;
        tick(2);
        cam_pclk = 1'b1;
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (fb_we === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("t2_latency", lat, 4);
        tick(2);
        send_byte(8'h00);
        send_byte(8'h1F);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        tick(4);
        frame_close();
        check("t2_nwr", wr_addr.size(), 2);
        check("t2_green", log_data(0), 32'h0F0);
        check("t2_blue",  log_data(1), 32'h00F);
        check("t2_addr1", log_addr(1), 1);
        check("t2_err_short", 32'(frame_err), 1);

        // ---------------- 3: odd byte on a line, frame one pixel short ----------------
        clr_log();
        frame_begin();
        check("t3_err_cleared", 32'(frame_err), 0);
        send_line(3, 8'h07, 8'hE0);
        send_line(12, 8'h00, 8'h1F);
        frame_close();
        check("t3_nwr", wr_addr.size(), 7);
        check("t3_data0", log_data(0), 32'h0F0);
        check("t3_data1", log_data(1), 32'h00F);
        check("t3_addr6", log_addr(6), 6);
        check("t3_done", done_cnt, 1);
        check("t3_err", 32'(frame_err), 1);

        // ---------------- 4: overlong frame, then a good frame ----------------
        clr_log();
        frame_begin();
        send_line(10, 8'hF8, 8'h00);
        send_line(10, 8'h07, 8'hE0);
        frame_close();
        check("t4_nwr", wr_addr.size(), 8);
        check("t4_last_addr", log_addr(7), 7);
        check("t4_last_data", log_data(7), 32'h0F0);
        check("t4_err", 32'(frame_err), 1);
        check("t4_addr_hold", 32'(fb_addr), 7);
        clr_log();
        frame_begin();
        check("t4_err_clr", 32'(frame_err), 0);
        send_line(8, 8'h00, 8'h1F);
        send_line(8, 8'h00, 8'h1F);
        frame_close();
        check("t4b_nwr", wr_addr.size(), 8);
        check("t4b_addr0", log_addr(0), 0);
        check("t4b_data0", log_data(0), 32'h00F);
        check("t4b_err", 32'(frame_err), 0);

        // ---------------- 5: capture_en drops mid-frame ----------------
        clr_log();
        frame_begin();
        send_line(8, 8'hF8, 8'h00);
        capture_en = 1'b0;
        send_line(8, 8'hF8, 8'h00);
        frame_close();
        check("t5_nwr", wr_addr.size(), 8);
        check("t5_done", done_cnt, 1);
        clr_log();
        frame_begin();
        send_line(8, 8'hF8, 8'h00);
        send_line(8, 8'hF8, 8'h00);
        frame_close();
        check("t5_idle_nwr", wr_addr.size(), 0);
        check("t5_idle_done", done_cnt, 0);
        capture_en = 1'b1;
        tick(2);

        // ---------------- 6: reset mid-frame ----------------
        clr_log();
        frame_begin();
        send_line(6, 8'h07, 8'hE0);
        check("t6_prerst_nwr", wr_addr.size(), 3);
        check("t6_prerst_addr", 32'(fb_addr), 2);
        rst = 1'b1;
        tick(2);
        check("t6_rst_we",   32'(fb_we), 0);
        check("t6_rst_addr", 32'(fb_addr), 0);
        check("t6_rst_data", 32'(fb_data), 0);
        check("t6_rst_err",  32'(frame_err), 0);
        rst = 1'b0;
        tick(2);
        clr_log();
        send_line(10, 8'hF8, 8'h00);
        frame_close();
        check("t6_resume_nwr", wr_addr.size(), 0);
        check("t6_resume_done", done_cnt, 0);
        frame_begin();
        send_line(8, 8'h00, 8'h1F);
        send_line(8, 8'h00, 8'h1F);
        frame_close();
        check("t6_new_nwr", wr_addr.size(), 8);
        check("t6_new_addr0", log_addr(0), 0);
        check("t6_new_addr7", log_addr(7), 7);
        check("t6_new_done", done_cnt, 1);
        check("t6_new_err", 32'(frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
